// File: rtl/download_pkg.sv
// Shared types and constants for the ioctl download packer.
package download_pkg;

  // Bytes per packed SDRAM word.
  localparam int LANES  = 4;
  localparam int LANE_W = $clog2(LANES);

  // Write-side FSM states.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  // One packed SDRAM write: word address plus little-endian data.
  typedef struct packed {
    logic [22:0] addr;
    logic [31:0] data;
  } word_t;

endpackage

// File: rtl/word_fifo.sv
// Small synchronous FIFO of packed words with show-ahead head output.
// A push while full is accepted only when a pop happens in the same cycle.
module word_fifo
  import download_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  word_t push_data,
  input  logic  pop,
  output word_t head,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(DEPTH);

  word_t          mem_q [DEPTH];
  word_t          mem_d [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           do_push_s, do_pop_s;

  assign full  = (count_q == (AW + 1)'(DEPTH));
  assign empty = (count_q == (AW + 1)'(0));
  assign head  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    do_pop_s  = pop & ~empty;
    do_push_s = push & (~full | do_pop_s);
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/download_packer.sv
// Packs ioctl download bytes into 32-bit little-endian SDRAM words and
// writes them out through a small FIFO with a req/ack handshake.
module download_packer
  import download_pkg::*;
#(
  parameter logic [22:0] BASE_ADDR  = 23'h0,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  input  logic        ioctl_download,
  output logic [22:0] sdram_addr,
  output logic [31:0] sdram_data,
  output logic        sdram_we,
  output logic        sdram_req,
  input  logic        sdram_ack,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  logic              dl_q, dl_d;
  logic              part_valid_q, part_valid_d;
  logic [22:0]       part_addr_q, part_addr_d;
  logic [31:0]       part_data_q, part_data_d;
  logic              push_valid_q, push_valid_d;
  word_t             push_word_q, push_word_d;
  state_t            state_q, state_d;
  logic              overflow_q, overflow_d;
  logic              armed_q, armed_d;

  logic              wr_s, rise_s, fall_s, evict_s, flush_s;
  logic [22:0]       word_addr_s;
  logic [LANE_W-1:0] lane_s;
  logic [31:0]       base_data_s, merged_s;
  logic              fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s;
  word_t             fifo_in_s, fifo_head_s;
  logic              busy_s;

  word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push_s),
    .push_data (fifo_in_s),
    .pop       (fifo_pop_s),
    .head      (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Byte packer: merge bytes into the partial word, evict on address change,
  // flush on download end, and stage completed words for a push next cycle.
  // An evict/flush never coincides with a staged push because completing a
  // word always leaves the partial slot empty.
  always_comb begin
    wr_s        = ioctl_wr & ioctl_download;
    rise_s      = ioctl_download & ~dl_q;
    fall_s      = ~ioctl_download & dl_q;
    word_addr_s = BASE_ADDR + {5'd0, ioctl_addr[19:2]};
    lane_s      = ioctl_addr[1:0];
    evict_s     = wr_s & ~rise_s & part_valid_q & (part_addr_q != word_addr_s);
    flush_s     = fall_s & part_valid_q;
    base_data_s = (part_valid_q & ~rise_s & ~evict_s) ? part_data_q : 32'h0;
    merged_s    = base_data_s;
    merged_s[{lane_s, 3'b000} +: 8] = ioctl_data;

    dl_d         = ioctl_download;
    part_valid_d = part_valid_q;
    part_addr_d  = part_addr_q;
    part_data_d  = part_data_q;
    push_valid_d = 1'b0;
    push_word_d  = push_word_q;

    if (rise_s | flush_s) begin
      part_valid_d = 1'b0;
      part_addr_d  = 23'h0;
      part_data_d  = 32'h0;
    end else begin
      part_valid_d = part_valid_q;
    end

    if (wr_s) begin
      if (lane_s == LANE_W'(LANES - 1)) begin
        push_valid_d     = 1'b1;
        push_word_d.addr = word_addr_s;
        push_word_d.data = merged_s;
        part_valid_d     = 1'b0;
        part_addr_d      = 23'h0;
        part_data_d      = 32'h0;
      end else begin
        part_valid_d = 1'b1;
        part_addr_d  = word_addr_s;
        part_data_d  = merged_s;
      end
    end else begin
      push_valid_d = 1'b0;
    end

    fifo_push_s = push_valid_q | evict_s | flush_s;
    if (push_valid_q) begin
      fifo_in_s = push_word_q;
    end else begin
      fifo_in_s.addr = part_addr_q;
      fifo_in_s.data = part_data_q;
    end
  end

  // Write FSM, overflow tracking and done arming.
  always_comb begin
    state_d    = state_q;
    fifo_pop_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty_s) begin
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (sdram_ack) begin
          fifo_pop_s = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    overflow_d = overflow_q | (fifo_push_s & fifo_full_s & ~fifo_pop_s);

    busy_s = ~reset & (ioctl_download | ~fifo_empty_s | part_valid_q |
                       push_valid_q | (state_q == REQ));
    if (ioctl_download) begin
      armed_d = 1'b1;
    end else if (busy_s) begin
      armed_d = armed_q;
    end else begin
      armed_d = 1'b0;
    end
  end

  // All packer and FSM state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dl_q         <= 1'b0;
      part_valid_q <= 1'b0;
      part_addr_q  <= 23'h0;
      part_data_q  <= 32'h0;
      push_valid_q <= 1'b0;
      push_word_q  <= '0;
      state_q      <= IDLE;
      overflow_q   <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      dl_q         <= dl_d;
      part_valid_q <= part_valid_d;
      part_addr_q  <= part_addr_d;
      part_data_q  <= part_data_d;
      push_valid_q <= push_valid_d;
      push_word_q  <= push_word_d;
      state_q      <= state_d;
      overflow_q   <= overflow_d;
      armed_q      <= armed_d;
    end
  end

  assign sdram_req  = (state_q == REQ);
  assign sdram_we   = (state_q == REQ);
  assign sdram_addr = (state_q == REQ) ? fifo_head_s.addr : 23'h0;
  assign sdram_data = (state_q == REQ) ? fifo_head_s.data : 32'h0;
  assign busy       = busy_s;
  assign done       = armed_q & ~busy_s;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_download_packer.sv
// Directed scoreboard bench for download_packer (BASE_ADDR=0x100, depth 4).
module tb_download_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;
  logic        ioctl_download;
  logic [22:0] sdram_addr;
  logic [31:0] sdram_data;
  logic        sdram_we;
  logic        sdram_req;
  logic        sdram_ack;
  logic        busy;
  logic        done;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [54:0] exp_q[$];

  always #5 clk = ~clk;

  download_packer #(.BASE_ADDR(23'h100), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .ioctl_addr     (ioctl_addr),
    .ioctl_data     (ioctl_data),
    .ioctl_wr       (ioctl_wr),
    .ioctl_download (ioctl_download),
    .sdram_addr     (sdram_addr),
    .sdram_data     (sdram_data),
    .sdram_we       (sdram_we),
    .sdram_req      (sdram_req),
    .sdram_ack      (sdram_ack),
    .busy           (busy),
    .done           (done),
    .overflow       (overflow)
  );

  // Count done pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [19:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Wait (bounded) for a request, hold it `delay` cycles, then ack it.
  task automatic ack_one(input int delay, output logic [22:0] a,
                         output logic [31:0] d, output bit ok);
    ok = 1'b0;
    a  = '0;
    d  = '0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (sdram_req === 1'b1) ok = 1'b1;
    end
    if (ok) begin
      repeat (delay) @(posedge clk);
      #1;
      a = sdram_addr;
      d = sdram_data;
      sdram_ack = 1'b1;
      tick();
      sdram_ack = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({sdram_req, sdram_we, busy, done, overflow} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b required 00000",
               {sdram_req, sdram_we, busy, done, overflow});
    end
    checks++;
    if ({sdram_addr, sdram_data} !== 55'h0) begin
      errors++;
      $display("FAIL reset_bus got %h required 0", {sdram_addr, sdram_data});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_word();
    logic [22:0] a; logic [31:0] d; bit ok; logic [54:0] exp_w; int d0;
    d0 = done_cnt;
    ioctl_download = 1'b1;
    tick();
    wr_byte(20'd0, 8'h11); wr_byte(20'd1, 8'h22);
    wr_byte(20'd2, 8'h33); wr_byte(20'd3, 8'h44);
    exp_q.push_back({23'h100, 32'h44332211});
    ack_one(3, a, d, ok);
    exp_w = exp_q.pop_front();
    checks++;
    if (!ok) begin
      errors++; $display("FAIL single_timeout no request seen");
    end else if ({a, d} !== exp_w) begin
      errors++; $display("FAIL single_word got %h required %h", {a, d}, exp_w);
    end
    checks++;
    if (sdram_req !== 1'b0) begin
      errors++; $display("FAIL single_req_after_ack got %b required 0", sdram_req);
    end
    ioctl_download = 1'b0;
    repeat (10) tick();
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++; $display("FAIL single_done got %0d pulses required 1", done_cnt - d0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL single_busy got %b required 0", busy);
    end
  endtask

  task automatic test_flush();
    logic [22:0] a; logic [31:0] d; bit ok; logic [54:0] exp_w; int d0;
    d0 = done_cnt;
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) wr_byte(20'(i), 8'(8'h11 * (i + 1)));
    exp_q.push_back({23'h100, 32'h44332211});
    exp_q.push_back({23'h101, 32'h00006655});
    ioctl_download = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ack_one(1, a, d, ok);
      exp_w = exp_q.pop_front();
      checks++;
      if (!ok) begin
        errors++; $display("FAIL flush_timeout word %0d", k);
      end else if ({a, d} !== exp_w) begin
        errors++; $display("FAIL flush_word %0d got %h required %h", k, {a, d}, exp_w);
      end
    end
    repeat (10) tick();
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++; $display("FAIL flush_done got %0d pulses required 1", done_cnt - d0);
    end
  endtask

  task automatic test_evict();
    logic [22:0] a; logic [31:0] d; bit ok; logic [54:0] exp_w;
    ioctl_download = 1'b1;
    tick();
    wr_byte(20'd2, 8'hAA);
    wr_byte(20'd9, 8'hBB);
    exp_q.push_back({23'h100, 32'h00AA0000});
    exp_q.push_back({23'h102, 32'h0000BB00});
    ioctl_download = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ack_one(0, a, d, ok);
      exp_w = exp_q.pop_front();
      checks++;
      if (!ok) begin
        errors++; $display("FAIL evict_timeout word %0d", k);
      end else if ({a, d} !== exp_w) begin
        errors++; $display("FAIL evict_word %0d got %h required %h", k, {a, d}, exp_w);
      end
    end
    repeat (5) tick();
  endtask

  task automatic test_overflow();
    logic [22:0] a; logic [31:0] d; bit ok; logic [54:0] exp_w; int d0; int seen;
    d0 = done_cnt;
    ioctl_download = 1'b1;
    tick();
    for (int w = 0; w < 6; w++) begin
      for (int b = 0; b < 4; b++) wr_byte(20'(4 * w + b), 8'(4 * w + b + 1));
      if (w < 4) exp_q.push_back({23'(23'h100 + w), 8'(4 * w + 4), 8'(4 * w + 3),
                                  8'(4 * w + 2), 8'(4 * w + 1)});
    end
    tick();
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_flag got %b required 1", overflow);
    end
    ioctl_download = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ack_one(2, a, d, ok);
      exp_w = exp_q.pop_front();
      checks++;
      if (!ok) begin
        errors++; $display("FAIL ovf_timeout word %0d", k);
      end else if ({a, d} !== exp_w) begin
        errors++; $display("FAIL ovf_word %0d got %h required %h", k, {a, d}, exp_w);
      end
    end
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (sdram_req === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL ovf_extra_writes got %0d req cycles required 0", seen);
    end
    checks++;
    if (overflow !== 1'b1 || done_cnt - d0 !== 1) begin
      errors++; $display("FAIL ovf_sticky_done got ovf=%b done=%0d required ovf=1 done=1",
                         overflow, done_cnt - d0);
    end
  endtask

  task automatic test_reset_in_req();
    bit ok; int d0; int seen;
    do_reset();
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) wr_byte(20'(i), 8'(8'h50 + i));
    ioctl_download = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (sdram_req === 1'b1) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rst_req_timeout no request seen");
    end
    tick();
    d0 = done_cnt;
    reset = 1'b1;
    #1;
    checks++;
    if ({sdram_req, sdram_we, busy, done} !== 4'b0) begin
      errors++; $display("FAIL rst_req_flags got %b required 0000",
                         {sdram_req, sdram_we, busy, done});
    end
    tick();
    reset = 1'b0;
    tick();
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (sdram_req === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_req_after got req=%0d busy=%b required 0 0", seen, busy);
    end
    checks++;
    if (done_cnt !== d0) begin
      errors++; $display("FAIL rst_req_done got %0d pulses required 0", done_cnt - d0);
    end
  endtask

  task automatic test_ack_full_push();
    logic [22:0] a; logic [31:0] d; bit ok; logic [54:0] exp_w; int d0; int seen;
    do_reset();
    exp_q.delete();
    d0 = done_cnt;
    ioctl_download = 1'b1;
    tick();
    for (int w = 0; w < 5; w++)
      exp_q.push_back({23'(23'h100 + w), 8'(4 * w + 4), 8'(4 * w + 3),
                       8'(4 * w + 2), 8'(4 * w + 1)});
    for (int i = 0; i < 19; i++) wr_byte(20'(i), 8'(i + 1));
    checks++;
    if (sdram_req !== 1'b1) begin
      errors++; $display("FAIL full_req got %b required 1", sdram_req);
    end
    a = sdram_addr;
    d = sdram_data;
    ioctl_addr = 20'd19;
    ioctl_data = 8'd20;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
    sdram_ack  = 1'b1;
    tick();
    sdram_ack  = 1'b0;
    exp_w = exp_q.pop_front();
    checks++;
    if ({a, d} !== exp_w) begin
      errors++; $display("FAIL full_head got %h required %h", {a, d}, exp_w);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL full_overflow got %b required 0", overflow);
    end
    ioctl_download = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ack_one(1, a, d, ok);
      exp_w = exp_q.pop_front();
      checks++;
      if (!ok) begin
        errors++; $display("FAIL full_timeout word %0d", k + 1);
      end else if ({a, d} !== exp_w) begin
        errors++; $display("FAIL full_word %0d got %h required %h", k + 1, {a, d}, exp_w);
      end
    end
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (sdram_req === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || overflow !== 1'b0 || done_cnt - d0 !== 1) begin
      errors++; $display("FAIL full_end got req=%0d ovf=%b done=%0d required 0 0 1",
                         seen, overflow, done_cnt - d0);
    end
  endtask

  initial begin
    reset          = 1'b1;
    ioctl_addr     = 20'h0;
    ioctl_data     = 8'h0;
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    sdram_ack      = 1'b0;
    test_reset();
    test_single_word();
    test_flush();
    test_evict();
    test_overflow();
    test_reset_in_req();
    test_ack_full_push();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/download_packer.md
DOWNLOAD_PACKER -- requirements
Module: download_packer

Interface
REQ-001 Parameters, one per line:
- BASE_ADDR, 23'h0, SDRAM 32-bit word address of ioctl byte 0.
- FIFO_DEPTH, 4, packed-word FIFO entries; power of two, at least 2.

REQ-002 Ports, one per line:
- clk, in, 1, system clock (96 MHz); the only clock.
- reset, in, 1, asynchronous, active-high.
- ioctl_addr, in, 20, byte address of the downloaded ROM byte.
- ioctl_data, in, 8, byte value.
- ioctl_wr, in, 1, one-cycle byte strobe.
- ioctl_download, in, 1, high for the whole download.
- sdram_addr, out, 23, word address.
- sdram_data, out, 32, write data.
- sdram_we, out, 1, write enable.
- sdram_req, out, 1, request.
- sdram_ack, in, 1, one-cycle acceptance pulse.
- busy, out, 1, download in progress or words pending.
- done, out, 1, one-cycle pulse when the download is fully written.
- overflow, out, 1, sticky flag: a word was dropped.

Function
REQ-003 Each byte SHALL be packed little-endian: lane ioctl_addr[1:0] maps to bits [8*lane+7 : 8*lane] of the word being assembled.
REQ-004 The word address SHALL be BASE_ADDR + ioctl_addr[19:2], zero-extended; a sum wrapping past 23 bits SHALL wrap silently.
REQ-005 A word SHALL be pushed into the FIFO one cycle after the ioctl_wr that writes lane 3.
REQ-006 On ioctl_wr whose word address differs from that of a partial (non-empty, lane 3 not yet written) word, the partial word SHALL be pushed first and the new byte SHALL start a fresh word in the same cycle.
REQ-007 On the falling edge of ioctl_download, a pending partial word SHALL be pushed (flush).
REQ-008 Unwritten lanes of a pushed word SHALL be zero.
REQ-009 The FSM SHALL have states IDLE and REQ.
- IDLE -> REQ when the FIFO is non-empty.
- REQ -> IDLE on sdram_ack, which pops the FIFO head.
REQ-010 In REQ, sdram_req and sdram_we SHALL be 1, and sdram_addr/sdram_data SHALL equal the FIFO head, held stable until ack.
REQ-011 sdram_req SHALL be 0 in the cycle after ack, so there is at least one idle cycle between requests.
REQ-012 sdram_ack while in IDLE SHALL be ignored.
REQ-013 A push and a pop in the same cycle SHALL both take effect; occupancy is unchanged.
REQ-014 A push when the FIFO is full and no pop occurs in that cycle SHALL drop the word and set overflow; overflow stays set until reset.
REQ-015 busy SHALL equal ioctl_download OR FIFO non-empty OR partial word pending OR sdram_req.
REQ-016 done SHALL pulse exactly once, on the first cycle busy falls after ioctl_download has been high.
REQ-017 A new rising edge of ioctl_download SHALL clear the packer but not the FIFO; queued words are still written.
REQ-018 ioctl_wr while ioctl_download is low SHALL be ignored.

Reset
REQ-019 Asserting reset SHALL immediately force:
- sdram_req=0, sdram_we=0, sdram_addr=0, sdram_data=0;
- busy=0, done=0, overflow=0;
- FSM=IDLE;
- FIFO empty and partial word discarded.
REQ-020 Reset asserted during REQ SHALL abandon the request with no retry; a later sdram_ack SHALL be ignored.

Structure
REQ-021 Package download_pkg SHALL hold:
- the state_t enum (IDLE, REQ);
- the packed word type (23-bit address + 32-bit data);
- constant LANES=4.
REQ-022 The FIFO SHALL be one sub-module, word_fifo: synchronous, parameterised depth, same clk/reset, with full and empty flags and show-ahead read data.
REQ-023 The packer and the FSM SHALL live in download_packer.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Bytes 11,22,33,44 at addresses 0..3, BASE_ADDR=0x100, ack after 3 cycles -> one write, addr 0x100, data 0x44332211, then done pulse after download falls.
- Bytes at addresses 0..5, then download falls -> writes 0x44332211 @0x100, then 0x00006655 @0x101 (flush), then one done pulse.
- Byte 0xAA at address 2, then byte 0xBB at address 9 -> 0x00AA0000 @word0 pushed before 0x0000BB00 @word2 (REQ-006).
- FIFO_DEPTH=4, ack held low, 6 full words written -> first 4 words written in order after ack resumes, overflow=1, words 5-6 absent.
- Reset during REQ with FIFO holding 3 words -> req=0 next edge, busy=0, no further writes, stray ack ignored.
- Ack pulse coinciding with a push when FIFO full -> no overflow, occupancy stays 4.
